// File: rtl/eth_stream_pkg.sv
// Shared types and helpers for the MAC TX stream arbitration blocks.
package eth_stream_pkg;

  localparam int MAX_REQS = 32;
  localparam int MAX_SELW = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                found;
    logic [MAX_SELW-1:0] idx;
  } rr_pick_t;

  // A one-requester-wide select still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of req[0..n-1], scanning cyclically upward from prio.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQS-1:0] req,
                                       input int prio, input int n);
    rr_pick_t res;
    int       j;
    res = '0;
    for (int k = 0; k < MAX_REQS; k++) begin
      if (k < n) begin
        j = prio + k;
        if (j >= n) j = j - n;
        if (!res.found && req[j[MAX_SELW-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j[MAX_SELW-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready buffer with a registered ready_in; output is
// taken straight from storage unless the pass-through path is enabled.
module skid_buffer #(
  parameter bit PASSTHRU       = 1'b0,
  parameter bit NOBACKPRESSURE = 1'b0,
  parameter bit OUT_REG        = 1'b0,
  parameter int DATAW          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out
);
  // A registered output cannot also forward the input combinationally.
  localparam bit BYPASS = PASSTHRU && !OUT_REG;

  logic [DATAW-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             ready_q;
  logic             empty, push, pop, wr_en, rd_en;

  assign empty     = (count_q == 2'd0);
  assign ready_in  = NOBACKPRESSURE ? 1'b1 : ready_q;
  assign valid_out = !empty || (BYPASS && valid_in);
  assign data_out  = (BYPASS && empty) ? data_in : mem_q[rd_ptr_q];
  assign push      = valid_in && ready_in;
  assign pop       = valid_out && ready_out;
  assign wr_en     = push && (count_q != 2'd2) && !(BYPASS && empty && ready_out);
  assign rd_en     = pop && !empty;
  assign count_d   = count_q + {1'b0, wr_en} - {1'b0, rd_en};

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
      if (wr_en) wr_ptr_q <= ~wr_ptr_q;
      if (rd_en) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin packet arbiter: merges NUM_REQS valid/ready streams onto one
// registered output stream, holding each grant until the packet's last beat.
//
// state  | meaning
// IDLE   | no packet in flight; the round-robin candidate may push
// LOCKED | mid-packet; only owner may push until its last beat is accepted
module stream_rr_arbiter
  import eth_stream_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int DATAW       = 8,
  parameter bit LOCK_PACKET = 1'b1,
  parameter int SELW        = clog2_min1(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  input  logic [NUM_REQS-1:0]       last_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic                      last_out,
  output logic [SELW-1:0]           sel_out,
  input  logic                      ready_out
);
  localparam int STGW = DATAW + 1 + SELW;

  arb_state_t       state_q, state_d;
  logic [SELW-1:0]  owner_q, owner_d;
  logic [SELW-1:0]  prio_q, prio_d;
  logic [SELW-1:0]  grant_idx;
  logic             grant_vld, beat_vld, push, push_last, stage_ready;
  logic [DATAW-1:0] push_data;
  logic [STGW-1:0]  stage_out;
  rr_pick_t         pick;

  function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] v);
    return (v == SELW'(NUM_REQS - 1)) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    pick      = rr_pick(MAX_REQS'(valid_in), int'(prio_q), NUM_REQS);
    grant_idx = SELW'(pick.idx);
    grant_vld = pick.found;
    // The owner keeps its grant even while it has no beat to offer.
    if (state_q == LOCKED) begin
      grant_idx = owner_q;
      grant_vld = 1'b1;
    end

    ready_in = '0;
    if (grant_vld) ready_in[grant_idx] = stage_ready;

    push_data = '0;
    push_last = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant_idx == SELW'(i)) begin
        push_data = data_in[i*DATAW +: DATAW];
        push_last = last_in[i];
      end
    end
    beat_vld = grant_vld && valid_in[grant_idx];
    push     = beat_vld && stage_ready;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    if (push) begin
      if (state_q == IDLE) begin
        if (push_last || !LOCK_PACKET) begin
          prio_d = wrap_inc(grant_idx);
        end else begin
          state_d = LOCKED;
          owner_d = grant_idx;
        end
      end else if (push_last) begin
        state_d = IDLE;
        prio_d  = wrap_inc(owner_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  skid_buffer #(
    .PASSTHRU       (1'b0),
    .NOBACKPRESSURE (1'b0),
    .OUT_REG        (1'b0),
    .DATAW          (STGW)
  ) u_stage (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (beat_vld),
    .data_in   ({grant_idx, push_last, push_data}),
    .ready_in  (stage_ready),
    .valid_out (valid_out),
    .data_out  (stage_out),
    .ready_out (ready_out)
  );

  assign {sel_out, last_out, data_out} = stage_out;

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin arbiter that merges NUM_REQS valid/ready packet streams onto one output stream. Each grant is held for a whole packet, delimited by `last`. The output is registered through a 2-entry skid stage, so no combinational path runs from `ready_out` to any `ready_in`. It sits in front of shared MAC TX resources (TX FIFO, CRC/framer), where control, pause and data sources compete for one transmit path.

## Interface
- NUM_REQS, 4: number of requesters; must be ≥ 2.
- DATAW, 8: data width per beat.
- LOCK_PACKET, 1:
  - 1: hold the grant until the beat with `last` is accepted.
  - 0: re-arbitrate on every beat.
- SELW, `$clog2(NUM_REQS)`: derived width of the source index.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  NUM_REQS  per-requester beat valid.
- data_in  in  NUM_REQS*DATAW  requester i occupies bits [i*DATAW +: DATAW].
- last_in  in  NUM_REQS  per-requester end-of-packet flag.
- ready_in  out  NUM_REQS  per-requester accept; one-hot or zero.
- valid_out  out  1  output beat valid.
- data_out  out  DATAW  output beat data.
- last_out  out  1  output end-of-packet flag.
- sel_out  out  SELW  index of the requester that produced the current output beat.
- ready_out  in  1  downstream accept.

## Operation
- Registers:
  - `state` ∈ {IDLE, LOCKED}.
  - `owner` [SELW].
  - `prio` [SELW]: round-robin pointer.
- IDLE:
  - Candidate = first i with valid_in[i], searching cyclically from `prio`.
  - ready_in[candidate] = stage_ready. All other ready_in bits are 0.
- Accept (push): valid_in[c] && ready_in[c]. The beat {data, last, c} enters the skid stage.
- Transitions on push in IDLE:
  - last_in[c]=1 or LOCK_PACKET=0 → stay IDLE; prio ← (c+1) mod NUM_REQS.
  - Otherwise → LOCKED; owner ← c.
- LOCKED:
  - Only `owner` is eligible: ready_in[owner] = stage_ready, all others 0.
  - valid_in[owner]=0 → wait in LOCKED indefinitely; other requesters are not served.
  - Push with last_in[owner]=1 → IDLE; prio ← (owner+1) mod NUM_REQS.
- Wrap-around: prio and owner wrap modulo NUM_REQS. When NUM_REQS is not a power of two, values ≥ NUM_REQS never occur.
- Skid stage:
  - 2-entry buffer of width DATAW+1+SELW. stage_ready is a register, deasserted only when both entries are full.
  - Pop = valid_out && ready_out.
  - Simultaneous push and pop while full is impossible, because stage_ready=0 when full.
  - Output order equals accept order.
- No beat is dropped or duplicated. A requester's valid_in and data_in must stay stable until its ready_in is asserted (AXI-Stream rule; not checked).
- Reset mid-operation: any buffered beats and any partial packet are discarded; all state returns to reset values.

## Timing
- Reset values:
  - valid_out=0, stage_ready=1.
  - state=IDLE, prio=0, owner=0.
  - data_out, last_out, sel_out: don't care while valid_out=0.
  - ready_in is combinational and equals 0 in the cycle after reset if no valid_in is asserted.
- Latency: a beat accepted in cycle N appears on valid_out in cycle N+1.
- Throughput: 1 beat/cycle with ready_out held high, including back-to-back packets from different requesters; there is no idle cycle at a grant switch.
- Backpressure: when ready_out drops, at most 2 beats are absorbed. stage_ready falls in the cycle after the second entry fills.
- ready_in depends combinationally on valid_in, state and stage_ready only, never on ready_out.
- Single-beat packet (last=1 on its first beat): the grant is released in the same cycle; the next arbitration uses the updated prio in the following cycle.

## Structure
- Shared package (`eth_stream_pkg`):
  - `arb_state_t` enum {IDLE, LOCKED}.
  - Function `rr_pick(req, prio)` returning the index and a found flag.
  - Function `clog2_min1`, so that SELW ≥ 1.
- Sub-module: the existing `skid_buffer` (PASSTHRU=0, NOBACKPRESSURE=0, OUT_REG=0, DATAW=DATAW+1+SELW) implements the output stage. The arbiter uses its `ready_in` output as stage_ready.

## Test plan
- Fairness, single-beat packets: NUM_REQS=4, all four valid continuously with last=1 on every beat, ready_out=1 → sel_out sequence 0,1,2,3,0,1…; one beat per cycle.
- Packet lock: req1 sends a 3-beat packet A1,A2,A3 (last on A3) while req2 is valid throughout → output A1,A2,A3 with sel=1, then req2's beat; ready_in[2] stays 0 until A3 is accepted.
- Lock stall: req0 starts a packet and then drops valid for 5 cycles while req3 is valid → req3 receives no ready_in during those cycles; req0's packet resumes and completes, then req3 is granted.
- Backpressure: continuous traffic; ready_out=0 for 4 cycles → exactly 2 beats are buffered, all ready_in are 0 from the following cycle, and no beat is lost or reordered after ready_out returns to 1.
- Pointer wrap: NUM_REQS=3, only req2 and req0 valid, prio=2 → grants alternate 2,0,2,0.
- Reset mid-packet: assert reset while LOCKED with 2 beats buffered → next cycle valid_out=0, all ready_in=0 with no valid_in, prio=0; the first new request from req1 is granted on its first valid cycle.
